// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register-file write controller.
package regfile_pkg;

  localparam int DATA_W   = 12;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer only moves when both requesters contend.
module rr_arbiter_2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_e rr_ptr_q, rr_ptr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= REQ_A;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (en) begin
      if (req_a && req_b) begin
        if (rr_ptr_q == REQ_A) begin
          gnt_a    = 1'b1;
          rr_ptr_d = REQ_B;
        end else begin
          gnt_b    = 1'b1;
          rr_ptr_d = REQ_A;
        end
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Owns the register-file write port: zero-fill walk after reset/clear, then
// round-robin sharing between ALU (A) and load (B) writeback with a 1-cycle output register.
module regfile_write_ctrl #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              init_done
);

  import regfile_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              arb_en, gnt_a, gnt_b;

  // No acceptance during clear request, so the pending write drains before the walk.
  assign arb_en = (state_q == RUN) && !clear_req && !reset;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        if (cnt_q == (ADDR_W+1)'(NUM_REGS - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (gnt_a) begin
      wr_en_d   = 1'b1;
      wr_addr_d = a_addr;
      wr_data_d = a_data;
    end else if (gnt_b) begin
      wr_en_d   = 1'b1;
      wr_addr_d = b_addr;
      wr_data_d = b_data;
    end
  end

  // rf_* come only from cnt_q or the output register; reset just masks them.
  always_comb begin
    rf_write_en   = 1'b0;
    rf_write_addr = '0;
    rf_data_in    = '0;
    init_done     = 1'b0;
    a_ready       = gnt_a;
    b_ready       = gnt_b;
    if (!reset) begin
      unique case (state_q)
        CLEAR: begin
          rf_write_en   = 1'b1;
          rf_write_addr = cnt_q[ADDR_W-1:0];
        end
        RUN: begin
          rf_write_en   = wr_en_q;
          rf_write_addr = wr_addr_q;
          rf_data_in    = wr_data_q;
          init_done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench: expected register-file writes are queued when stimulus is driven.
module tb_regfile_write_ctrl;

  typedef struct packed {
    logic [2:0]  addr;
    logic [11:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, clear_req;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [2:0]  a_addr, b_addr, rf_write_addr;
  logic [11:0] a_data, b_data, rf_data_in;
  logic        rf_write_en, init_done;

  wr_t sb_q[$];
  wr_t mon_exp;
  int  n_chk  = 0;
  int  n_fail = 0;

  regfile_write_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .clear_req     (clear_req),
    .a_valid       (a_valid),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .a_ready       (a_ready),
    .b_valid       (b_valid),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .b_ready       (b_ready),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_data_in    (rf_data_in),
    .init_done     (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic push(input logic [2:0] addr, input logic [11:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    sb_q.push_back(w);
  endtask

  task automatic expect_walk(input int n);
    for (int i = 0; i < n; i++) push(3'(i), 12'h000);
  endtask

  // Runs n walk cycles from the start of walk cycle 1; optional clear_req pulse at cycle pulse_at.
  task automatic walk_cycles(input int n, input int pulse_at);
    for (int k = 1; k <= n; k++) begin
      clear_req = (k == pulse_at);
      settle();
      chk("walk_init_done", 32'(init_done), 32'd0);
      chk("walk_a_ready", 32'(a_ready), 32'd0);
      chk("walk_b_ready", 32'(b_ready), 32'd0);
      tick();
      clear_req = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rf_write_en) begin
      if (sb_q.size() == 0) begin
        chk("rf_unexpected_write", 32'(rf_write_addr), 32'hFFFF_FFFF);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("rf_addr", 32'(rf_write_addr), 32'(mon_exp.addr));
        chk("rf_data", 32'(rf_data_in), 32'(mon_exp.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear_req = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;

    // Reset state
    tick();
    settle();
    chk("rst_write_en", 32'(rf_write_en), 32'd0);
    chk("rst_addr", 32'(rf_write_addr), 32'd0);
    chk("rst_data", 32'(rf_data_in), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    tick();

    // Initial walk with both requesters pending; neither may be served
    reset = 1'b0;
    a_valid = 1'b1; a_addr = 3'd7; a_data = 12'hFFF;
    b_valid = 1'b1; b_addr = 3'd6; b_data = 12'hEEE;
    expect_walk(8);
    walk_cycles(8, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    settle();
    chk("init_done_9th", 32'(init_done), 32'd1);
    chk("idle_a_ready", 32'(a_ready), 32'd0);

    // Single A write, latency 1
    tick();
    a_valid = 1'b1; a_addr = 3'd5; a_data = 12'hA3C;
    push(3'd5, 12'hA3C);
    settle();
    chk("t2_a_ready", 32'(a_ready), 32'd1);
    chk("t2_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    settle();
    chk("t2_rf_en", 32'(rf_write_en), 32'd1);
    tick();
    settle();
    chk("t2_rf_en_off", 32'(rf_write_en), 32'd0);

    // Contested for 4 cycles: A,B,A,B
    tick();
    a_valid = 1'b1; a_addr = 3'd1; a_data = 12'h111;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 12'h222;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      settle();
      chk("t3_a_ready", 32'(a_ready), 32'(i % 2 == 0));
      chk("t3_b_ready", 32'(b_ready), 32'(i % 2 == 1));
      if (i % 2 == 0) push(3'd1, 12'h111);
      else            push(3'd2, 12'h222);
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;

    // B alone three cycles, then contention must go to A
    b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      b_addr = 3'(i + 3);
      b_data = 12'(12'h450 + i);
      settle();
      chk("t4_b_ready", 32'(b_ready), 32'd1);
      push(3'(i + 3), 12'(12'h450 + i));
    end
    tick();
    a_valid = 1'b1; a_addr = 3'd0; a_data = 12'h0A0;
    b_addr = 3'd7; b_data = 12'h7B7;
    settle();
    chk("t4_contest_a", 32'(a_ready), 32'd1);
    chk("t4_contest_b", 32'(b_ready), 32'd0);
    push(3'd0, 12'h0A0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;

    // Pending write drains before clear walk; clear_req during walk ignored
    a_valid = 1'b1; a_addr = 3'd6; a_data = 12'h0F0;
    settle();
    chk("t5_a_ready", 32'(a_ready), 32'd1);
    push(3'd6, 12'h0F0);
    tick();
    a_valid = 1'b0;
    clear_req = 1'b1;
    b_valid = 1'b1; b_addr = 3'd3; b_data = 12'h333;
    settle();
    chk("t5_clr_b_ready", 32'(b_ready), 32'd0);
    chk("t5_clr_a_ready", 32'(a_ready), 32'd0);
    chk("t5_pending_en", 32'(rf_write_en), 32'd1);
    chk("t5_pending_addr", 32'(rf_write_addr), 32'd6);
    expect_walk(8);
    tick();
    clear_req = 1'b0;
    walk_cycles(8, 3);
    settle();
    chk("t5_run_again", 32'(init_done), 32'd1);
    chk("t5_b_served", 32'(b_ready), 32'd1);
    push(3'd3, 12'h333);
    tick();
    b_valid = 1'b0;
    settle();

    // Reset in the middle of a walk restarts it from address 0
    tick();
    clear_req = 1'b1;
    settle();
    chk("t6_clr_a_ready", 32'(a_ready), 32'd0);
    tick();
    clear_req = 1'b0;
    expect_walk(4);
    walk_cycles(4, 0);
    reset = 1'b1;
    settle();
    chk("t6_rst_write_en", 32'(rf_write_en), 32'd0);
    chk("t6_rst_init_done", 32'(init_done), 32'd0);
    tick();
    reset = 1'b0;
    expect_walk(8);
    walk_cycles(8, 0);
    settle();
    chk("t6_init_done", 32'(init_done), 32'd1);
    tick();
    settle();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
